// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: 33-bit word FIFO plus chip-select framing FSM that feeds
// a 32-bit SPI master one word at a time over its DV/ready handshake.
module spi_frame_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CS_SETUP_CLKS = 4,
  parameter int unsigned CS_HOLD_CLKS  = 4,
  parameter int unsigned CS_IDLE_CLKS  = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Push,
  input  logic [31:0]                   i_Push_Word,
  input  logic                          i_Push_Last,
  input  logic                          i_Abort,
  output logic                          o_Full,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic                          o_Overflow,
  output logic [31:0]                   o_TX_Word,
  output logic                          o_TX_DV,
  input  logic                          i_TX_Ready,
  output logic                          o_SPI_CS_n,
  output logic                          o_Busy,
  output logic                          o_Frame_Done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_WAIT_RDY, S_LAUNCH,
    S_WAIT_ACCEPT, S_WAIT_DONE, S_CS_HOLD, S_CS_IDLE
  } state_t;

  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_full, r_overflow;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cs_n, r_tx_dv, r_last, r_abort_pend, r_busy, r_frame_done;
  logic [31:0]   r_tx_word;

  logic          w_empty, w_full, w_push_ok, w_pop;
  logic [LW-1:0] w_count_nxt;
  logic [32:0]   w_head;

  // A push is refused while full (even with a simultaneous pop) and during abort.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LW'(FIFO_DEPTH));
  assign w_push_ok = i_Push && !w_full && !i_Abort;
  assign w_pop     = (r_state == S_LAUNCH);
  assign w_head    = r_mem[r_rd_ptr];

  // Next occupancy: abort flushes, push+pop together leave the level unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (i_Abort)                  w_count_nxt = '0;
    else if (w_push_ok && !w_pop) w_count_nxt = r_count + LW'(1);
    else if (!w_push_ok && w_pop) w_count_nxt = r_count - LW'(1);
  end

  // FIFO storage; data needs no reset, validity is tracked by r_count.
  always_ff @(posedge i_Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {i_Push_Last, i_Push_Word};
  end

  // FIFO pointers, level, full flag and overflow pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == LW'(FIFO_DEPTH));
      r_overflow <= i_Push && w_full && !i_Abort;
      if (i_Abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Framing FSM with registered CS, DV, word, busy and frame-done outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cs_n       <= 1'b1;
      r_tx_dv      <= 1'b0;
      r_tx_word    <= '0;
      r_last       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_tx_dv      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_Abort && !w_empty) begin
            r_state <= S_CS_SETUP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_CS_SETUP: begin
          if (i_Abort) begin
            r_state <= S_CS_HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(CS_SETUP_CLKS - 1)) begin
            r_state <= S_WAIT_RDY;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_RDY: begin
          if (i_Abort) begin
            r_state <= S_CS_HOLD;
            r_cnt   <= '0;
          end else if (i_TX_Ready && !w_empty) begin
            r_state   <= S_LAUNCH;
            r_tx_word <= w_head[31:0];
            r_last    <= w_head[32];
            r_tx_dv   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (i_Abort) r_abort_pend <= 1'b1;
          r_state <= S_WAIT_ACCEPT;
        end
        S_WAIT_ACCEPT: begin
          if (i_Abort) r_abort_pend <= 1'b1;
          if (!i_TX_Ready) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Abort) r_abort_pend <= 1'b1;
          if (i_TX_Ready) begin
            if (r_last || r_abort_pend || i_Abort) begin
              r_state <= S_CS_HOLD;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WAIT_RDY;
            end
          end
        end
        S_CS_HOLD: begin
          if (r_cnt == CW'(CS_HOLD_CLKS - 1)) begin
            r_state      <= S_CS_IDLE;
            r_cnt        <= '0;
            r_cs_n       <= 1'b1;
            r_frame_done <= 1'b1;
            r_abort_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CS_IDLE: begin
          if (r_cnt == CW'(CS_IDLE_CLKS - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Full       = r_full;
  assign o_Level      = r_count;
  assign o_Overflow   = r_overflow;
  assign o_TX_Word    = r_tx_word;
  assign o_TX_DV      = r_tx_dv;
  assign o_SPI_CS_n   = r_cs_n;
  assign o_Busy       = r_busy;
  assign o_Frame_Done = r_frame_done;

endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
- Controller in front of the 32-bit SPI master.
- Buffers outgoing 32-bit words in a small FIFO and drives chip-select around multi-word frames.
- Hands words to the master one at a time using its DV/ready handshake, with programmable CS setup, hold and idle timing.
- Sits between the core's SPI register interface and the SPI master.

Parameters:
- FIFO_DEPTH, 8, word FIFO entries; power of 2, >= 2.
- CS_SETUP_CLKS, 4, cycles CS is low before the first DV of a frame; >= 1.
- CS_HOLD_CLKS, 4, cycles CS stays low after the last word completes; >= 1.
- CS_IDLE_CLKS, 4, minimum cycles CS is high between frames; >= 1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous reset, active-high.
- i_Push  in  1  write a word into the FIFO.
- i_Push_Word  in  32  word to queue.
- i_Push_Last  in  1  word ends the frame; stored alongside the word.
- i_Abort  in  1  pulse: flush the FIFO and end the frame after the in-flight word.
- o_Full  out  1  FIFO full.
- o_Level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_Overflow  out  1  one-cycle pulse when a push is dropped.
- o_TX_Word  out  32  word presented to the SPI master.
- o_TX_DV  out  1  one-cycle data-valid pulse to the SPI master.
- i_TX_Ready  in  1  ready from the SPI master.
- o_SPI_CS_n  out  1  chip select, active low.
- o_Busy  out  1  high in every state except IDLE.
- o_Frame_Done  out  1  one-cycle pulse when CS deasserts at frame end.

Behaviour:
- Reset (async, i_Rst=1):
  - FIFO empty, o_Level=0, FSM=IDLE.
  - o_SPI_CS_n=1; o_TX_DV, o_Overflow, o_Busy, o_Frame_Done = 0; o_TX_Word=0.
  - All outputs are registered.
- FIFO: 33-bit entries (word plus last flag).
  - Push while full: dropped even if a pop occurs the same cycle; o_Overflow pulses next cycle.
  - Push and pop in the same cycle when not full: o_Level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: FIFO non-empty -> CS_SETUP. o_SPI_CS_n goes low on entry.
  - CS_SETUP: stays exactly CS_SETUP_CLKS cycles -> WAIT_RDY.
  - WAIT_RDY: i_TX_Ready=1 and FIFO non-empty -> LAUNCH. FIFO empty and no last word sent -> stay, CS held low indefinitely.
  - LAUNCH (1 cycle): pop FIFO head; o_TX_Word = head word; o_TX_DV=1 this cycle only; latch the last flag -> WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for i_TX_Ready=0 (master drops ready the cycle after DV) -> WAIT_DONE.
  - WAIT_DONE: wait for i_TX_Ready=1. Then: latched last flag or abort pending -> CS_HOLD; else -> WAIT_RDY.
  - CS_HOLD: CS_HOLD_CLKS cycles, CS low -> CS_IDLE. o_SPI_CS_n=1 and o_Frame_Done pulses on the transition.
  - CS_IDLE: CS_IDLE_CLKS cycles, CS high -> IDLE.
- Timing and word handling:
  - Push into an empty FIFO in IDLE sampled at cycle N: o_SPI_CS_n low at N+2.
  - o_TX_DV rises CS_SETUP_CLKS+1 cycles after CS falls when ready is already high.
  - o_TX_Word holds its value until the next LAUNCH.
  - Words of a frame are sent back-to-back with CS continuously low; DV is never re-issued while i_TX_Ready=0.
- Abort:
  - In IDLE or CS_IDLE: flush the FIFO only.
  - In CS_SETUP or WAIT_RDY: flush, go directly to CS_HOLD, no DV issued.
  - In LAUNCH, WAIT_ACCEPT or WAIT_DONE: flush; the in-flight word completes, then CS_HOLD.
  - Pushes in the same cycle as abort are discarded.
- Reset mid-frame: immediate return to reset values; CS goes high asynchronously.

Test Plan:
- Single frame: push 0xA5A5_0001 with last=1 in IDLE, master model ready -> CS low at N+2, one DV 5 cycles later with o_TX_Word=0xA5A5_0001, CS high CS_HOLD_CLKS cycles after ready returns, o_Frame_Done pulses once.
- Three-word frame: push 0x11111111, 0x22222222, 0x33333333 (last on third) -> three DVs in order, CS low continuously, exactly one Frame_Done.
- Stall: push one word with last=0, wait 200 cycles, push a word with last=1 -> CS low throughout the gap, second DV follows the push, then frame ends.
- Overflow: fill 8 entries while CS_SETUP holds, push a 9th -> o_Full=1, o_Overflow pulse, o_Level=8, 9th word never transmitted.
- Abort mid-word: four words queued, assert i_Abort during WAIT_DONE of word 1 -> word 1 completes, no further DV, o_Level=0, CS high after hold.
- Back-to-back frames: two single-word frames queued -> CS high for at least CS_IDLE_CLKS cycles between frames; async i_Rst mid-frame -> CS_n=1 immediately, o_Level=0.
